serdes_8b10b_link_sequencer: RTL
================================

// Module: serdes_8b10b_link_sequencer
// PURPOSE
//  Bring-up/recovery controller for the 8b10b SerDes link. Runs on free-running clk_ref (not clk_byte, which stops in MMCM reset).
//  Sequences MMCM reset, lock qualification, TX release with comma fill, RX release and comma alignment; monitors link health.
//  Retries on faults, escalating to MMCM reset on lock loss. Latches FAULT after MAX_RETRIES consecutive failures.
//  tx_rst/rx_rst/tx_comma are resynchronised into clk_byte by their consumers.
// PARAMETERS
//  MMCM_RST_CYCLES  16     cycles mmcm_rst held high per attempt (>=1)
//  LOCK_TIMEOUT     4096   max cycles in WAIT_LOCK before retry
//  SETTLE_CYCLES    8      consecutive locked cycles required; also TX_UP and RX_RST dwell
//  ALIGN_TIMEOUT    65535  max cycles in WAIT_ALIGN before retry
//  ERR_WINDOW       256    LINK_UP error-count window length
//  ERR_THRESH       4      code errors within one window that force an RX retry (>=1)
//  MAX_RETRIES      7      retries before FAULT; retry_cnt width RW=$clog2(MAX_RETRIES+1)
// PORTS
//  clk_ref       in   1   free-running reference clock; sole clock
//  rst_in        in   1   synchronous active-high reset
//  enable        in   1   1 = run sequence, 0 = return to IDLE
//  mmcm_locked   in   1   MMCM LOCKED, async; 2-flop synchronised internally (locked_s)
//  rx_aligned    in   1   RX comma alignment achieved (level, pre-synchronised)
//  rx_code_err   in   1   one-cycle pulse per 8b10b code/disparity error (pre-synchronised)
//  mmcm_rst      out  1   MMCM reset
//  tx_rst        out  1   TX datapath reset
//  rx_rst        out  1   RX datapath reset
//  tx_comma      out  1   force TX to transmit K28.5 idle
//  link_up       out  1   link qualified
//  fault         out  1   retries exhausted
//  state         out  4   current state encoding (below)
//  retry_cnt     out  RW  consecutive retry count, saturating at MAX_RETRIES
// BEHAVIOUR
//  Outputs: registered, Moore-decoded from state. Reset: state=IDLE, mmcm_rst=tx_rst=rx_rst=1,
//   tx_comma=link_up=fault=0, retry_cnt=0, all counters 0.
//  States / outputs (mmcm_rst, tx_rst, rx_rst, tx_comma):
//   0 IDLE 1,1,1,0 | 1 MMCM_RST 1,1,1,0 | 2 WAIT_LOCK 0,1,1,0 | 3 SETTLE 0,1,1,0
//   4 TX_UP 0,0,1,1 | 5 RX_RST 0,0,1,1 | 6 WAIT_ALIGN 0,0,0,1 | 7 LINK_UP 0,0,0,0 (link_up=1) | 8 FAULT 1,1,1,0 (fault=1)
//  Single state timer: cleared on every state entry; increments once per cycle in that state.
//  Priority per cycle: rst_in > enable=0 (any state -> IDLE; retry_cnt kept) > lock loss > other conditions.
//  Transitions:
//   IDLE: enable=1 -> MMCM_RST.
//   MMCM_RST: after exactly MMCM_RST_CYCLES cycles -> WAIT_LOCK.
//   WAIT_LOCK: locked_s=1 -> SETTLE; timer==LOCK_TIMEOUT-1 with locked_s=0 -> retry(MMCM).
//   SETTLE: locked_s=0 -> retry(MMCM); SETTLE_CYCLES consecutive locked cycles -> TX_UP.
//   TX_UP, RX_RST: after SETTLE_CYCLES cycles -> WAIT_ALIGN.
//   WAIT_ALIGN: rx_aligned=1 -> LINK_UP; timer==ALIGN_TIMEOUT-1 -> retry(RX).
//   LINK_UP: rx_aligned=0 or error threshold reached -> retry(RX).
//   FAULT: held until enable=0 or rst_in.
//   From TX_UP onward, locked_s=0 -> retry(MMCM), taking precedence over every RX condition in the same cycle.
//  retry(X): if retry_cnt==MAX_RETRIES -> FAULT; else retry_cnt+1 and go to MMCM_RST (X=MMCM) or RX_RST (X=RX).
//  Error window (LINK_UP only):
//   win_cnt runs 0..ERR_WINDOW-1 and wraps; err_cnt counts rx_code_err pulses.
//   Same cycle: if err_cnt+rx_code_err >= ERR_THRESH -> retry(RX).
//   On wrap, err_cnt loads rx_code_err, so an error on the wrap cycle counts in the new window.
//   A completed window with zero errors clears retry_cnt.
//   win_cnt and err_cnt are cleared on LINK_UP entry.
//  Mid-operation: rst_in forces reset values next cycle.
//   enable=0 drops link_up and asserts all resets next cycle; re-enable restarts from MMCM_RST.
// TESTING (bench params: MMCM_RST_CYCLES=4, SETTLE=4, LOCK_TIMEOUT=32, ALIGN_TIMEOUT=64, ERR_WINDOW=16, ERR_THRESH=3, MAX_RETRIES=2)
//  Nominal: enable=1, locked rises 10 cycles after mmcm_rst falls, aligned 20 cycles after rx_rst falls
//   -> mmcm_rst high exactly 4 cycles; state sequence 1,2,3,4,6,7; link_up=1, retry_cnt=0.
//  Lock glitch: locked low 1 cycle in SETTLE -> state 1 again, retry_cnt=1; a 2nd glitch -> retry_cnt=2.
//   A 3rd glitch -> FAULT, fault=1, all resets=1. enable=0 -> IDLE with fault=0; enable=1 -> full bring-up.
//  Align timeout: rx_aligned never rises -> 64 cycles in WAIT_ALIGN, then RX_RST for 4 cycles with mmcm_rst=0.
//   3rd timeout -> FAULT.
//  Error window: 3 rx_code_err pulses within 16 LINK_UP cycles -> RX_RST next cycle.
//   2 errors/window indefinitely -> stays LINK_UP, retry_cnt unchanged.
//   An error on the wrap cycle counts in the new window; a clean 16-cycle window after a retry -> retry_cnt=0.
//  Simultaneous: locked and rx_aligned fall in the same LINK_UP cycle -> MMCM_RST (not RX_RST).
//  Reset/enable mid-op: rst_in in WAIT_ALIGN -> IDLE and all reset values next cycle.
//   enable=0 in LINK_UP -> link_up=0, resets=1 next cycle.

Source files
------------

// File: rtl/serdes_8b10b_link_sequencer.sv
// rtl/serdes_8b10b_link_sequencer.sv - bring-up and recovery sequencer for the 8b10b SerDes link

module serdes_8b10b_link_sequencer #(
  parameter int MMCM_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT    = 4096,
  parameter int SETTLE_CYCLES   = 8,
  parameter int ALIGN_TIMEOUT   = 65535,
  parameter int ERR_WINDOW      = 256,
  parameter int ERR_THRESH      = 4,
  parameter int MAX_RETRIES     = 7,
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic          clk_ref,
  input  logic          rst_in,
  input  logic          enable,
  input  logic          mmcm_locked,
  input  logic          rx_aligned,
  input  logic          rx_code_err,
  output logic          mmcm_rst,
  output logic          tx_rst,
  output logic          rx_rst,
  output logic          tx_comma,
  output logic          link_up,
  output logic          fault,
  output logic [3:0]    state,
  output logic [RW-1:0] retry_cnt
);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_MMCM_RST   = 4'd1;
  localparam logic [3:0] S_WAIT_LOCK  = 4'd2;
  localparam logic [3:0] S_SETTLE     = 4'd3;
  localparam logic [3:0] S_TX_UP      = 4'd4;
  localparam logic [3:0] S_RX_RST     = 4'd5;
  localparam logic [3:0] S_WAIT_ALIGN = 4'd6;
  localparam logic [3:0] S_LINK_UP    = 4'd7;
  localparam logic [3:0] S_FAULT      = 4'd8;

  // One timer serves every state, so it must hold the longest terminal count.
  localparam int T_A  = (MMCM_RST_CYCLES > LOCK_TIMEOUT) ? MMCM_RST_CYCLES : LOCK_TIMEOUT;
  localparam int T_B  = (SETTLE_CYCLES > ALIGN_TIMEOUT) ? SETTLE_CYCLES : ALIGN_TIMEOUT;
  localparam int TMAX = (T_A > T_B) ? T_A : T_B;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int WW   = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
  localparam int EW   = $clog2(ERR_THRESH + 1);

  localparam logic [TW-1:0] T_MMCM   = TW'(MMCM_RST_CYCLES - 1);
  localparam logic [TW-1:0] T_LOCK   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_SETTLE = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] T_ALIGN  = TW'(ALIGN_TIMEOUT - 1);
  localparam logic [WW-1:0] W_LAST   = WW'(ERR_WINDOW - 1);
  localparam logic [EW:0]   E_THRESH = (EW + 1)'(ERR_THRESH);
  localparam logic [RW-1:0] R_MAX    = RW'(MAX_RETRIES);

  logic          locked_m, locked_s;
  logic [TW-1:0] timer;
  logic [WW-1:0] win_cnt, win_nxt;
  logic [EW-1:0] err_cnt, err_nxt;
  logic [EW:0]   err_sum;
  logic [RW-1:0] retry_nxt;
  logic [3:0]    state_nxt;
  logic          do_retry, retry_mmcm, wrap;

  // Next-state, retry and error-window decisions for the current cycle.
  always_comb begin
    state_nxt  = state;
    retry_nxt  = retry_cnt;
    win_nxt    = win_cnt;
    err_nxt    = err_cnt;
    do_retry   = 1'b0;
    retry_mmcm = 1'b0;
    wrap       = (win_cnt == W_LAST);
    // On the wrap cycle the error belongs to the window that is starting.
    err_sum    = wrap ? {{EW{1'b0}}, rx_code_err}
                      : ({1'b0, err_cnt} + {{EW{1'b0}}, rx_code_err});
    case (state)
      S_IDLE:       if (enable) state_nxt = S_MMCM_RST;
      S_MMCM_RST:   if (timer == T_MMCM) state_nxt = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (locked_s)             state_nxt = S_SETTLE;
        else if (timer == T_LOCK) begin do_retry = 1'b1; retry_mmcm = 1'b1; end
      end
      S_SETTLE: begin
        if (!locked_s)              begin do_retry = 1'b1; retry_mmcm = 1'b1; end
        else if (timer == T_SETTLE) state_nxt = S_TX_UP;
      end
      S_TX_UP, S_RX_RST: begin
        if (!locked_s)              begin do_retry = 1'b1; retry_mmcm = 1'b1; end
        else if (timer == T_SETTLE) state_nxt = S_WAIT_ALIGN;
      end
      S_WAIT_ALIGN: begin
        if (!locked_s)             begin do_retry = 1'b1; retry_mmcm = 1'b1; end
        else if (rx_aligned)       state_nxt = S_LINK_UP;
        else if (timer == T_ALIGN) do_retry = 1'b1;
      end
      S_LINK_UP: begin
        win_nxt = wrap ? '0 : win_cnt + WW'(1);
        err_nxt = err_sum[EW-1:0];
        if (!locked_s)                            begin do_retry = 1'b1; retry_mmcm = 1'b1; end
        else if (!rx_aligned || err_sum >= E_THRESH) do_retry = 1'b1;
        else if (wrap && err_cnt == '0)           retry_nxt = '0;
      end
      S_FAULT:      state_nxt = S_FAULT;
      default:      state_nxt = S_IDLE;
    endcase
    if (do_retry) begin
      if (retry_cnt == R_MAX) begin
        state_nxt = S_FAULT;
      end else begin
        retry_nxt = retry_cnt + RW'(1);
        state_nxt = retry_mmcm ? S_MMCM_RST : S_RX_RST;
      end
    end
    if (!enable) begin
      state_nxt = S_IDLE;
      retry_nxt = retry_cnt;
    end
    if (state_nxt != state) begin
      win_nxt = '0;
      err_nxt = '0;
    end
  end

  // State, counters, lock synchroniser and Moore outputs registered from the next state.
  always_ff @(posedge clk_ref) begin
    if (rst_in) begin
      locked_m  <= 1'b0;
      locked_s  <= 1'b0;
      state     <= S_IDLE;
      timer     <= '0;
      win_cnt   <= '0;
      err_cnt   <= '0;
      retry_cnt <= '0;
      mmcm_rst  <= 1'b1;
      tx_rst    <= 1'b1;
      rx_rst    <= 1'b1;
      tx_comma  <= 1'b0;
      link_up   <= 1'b0;
      fault     <= 1'b0;
    end else begin
      locked_m  <= mmcm_locked;
      locked_s  <= locked_m;
      state     <= state_nxt;
      timer     <= (state_nxt != state) ? '0 : timer + TW'(1);
      win_cnt   <= win_nxt;
      err_cnt   <= err_nxt;
      retry_cnt <= retry_nxt;
      mmcm_rst  <= 1'b0;
      tx_rst    <= 1'b0;
      rx_rst    <= 1'b0;
      tx_comma  <= 1'b0;
      link_up   <= 1'b0;
      fault     <= 1'b0;
      case (state_nxt)
        S_WAIT_LOCK, S_SETTLE: begin
          tx_rst <= 1'b1;
          rx_rst <= 1'b1;
        end
        S_TX_UP, S_RX_RST: begin
          rx_rst   <= 1'b1;
          tx_comma <= 1'b1;
        end
        S_WAIT_ALIGN: tx_comma <= 1'b1;
        S_LINK_UP:    link_up  <= 1'b1;
        S_FAULT: begin
          mmcm_rst <= 1'b1;
          tx_rst   <= 1'b1;
          rx_rst   <= 1'b1;
          fault    <= 1'b1;
        end
        default: begin
          mmcm_rst <= 1'b1;
          tx_rst   <= 1'b1;
          rx_rst   <= 1'b1;
        end
      endcase
    end
  end

endmodule
